dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder (slave) for the CPU's load/store port; it is the memory end of the load/store interface.
- Accepts one word read or write request at a time over a req/ready handshake.
- Inserts a configurable number of wait states, then completes the access.
- Flags misaligned and out-of-range accesses. Lets the CPU be moved from the zero-latency dmem onto a memory that can stall.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored; word index range is 0..DEPTH_WORDS-1.
- WAIT_CYCLES, 2, number of wait states inserted between acceptance and completion; legal range 0..15.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- req  input  1  request valid from the CPU.
- we  input  1  1 = store (sw), 0 = load (lw); sampled with req.
- addr  input  32  byte address (ALU result); sampled with req.
- wdata  input  32  store data (rt value); sampled with req.
- ready  output  1  one-cycle completion pulse.
- err  output  1  valid only while ready=1; 1 = access rejected.
- rdata  output  32  load data; valid from the ready cycle until the next accepted load completes.

Behaviour:
- Reset (rst_n=0, asynchronous, at any time including mid-transaction):
  - state=IDLE, ready=0, err=0, rdata=0, wait counter=0.
  - Any in-flight access is abandoned and no write occurs.
  - The storage array is not reset; its contents persist.
- States: IDLE, WAIT, RESP.
- IDLE:
  - On a rising edge with req=1, latch we/addr/wdata, load counter with WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, else go directly to RESP.
  - If req=0, stay in IDLE.
- WAIT:
  - Counter decrements on each edge. On the edge where the counter equals 1, go to RESP.
  - req and the input buses are ignored in WAIT.
  - Deasserting req here does not cancel the access.
- RESP:
  - ready=1 for exactly one cycle, then unconditionally go to IDLE.
  - A new request can be accepted at the earliest on the edge leaving RESP+1, i.e. one IDLE cycle minimum between transactions.
- Latency: if accepted on edge k, ready is high in the cycle following edge k+WAIT_CYCLES. WAIT_CYCLES=0 gives ready in the cycle immediately after acceptance.
- Access check (on latched values):
  - Word index = addr[31:2].
  - Misaligned when addr[1:0]!=0. Out of range when addr[31:2] >= DEPTH_WORDS.
  - Either condition gives err=1 during RESP.
- Store completion:
  - If no error, the array word is written on the edge entering RESP.
  - If error, no write. rdata is unchanged in either case.
- Load completion:
  - If no error, rdata is registered with the array word on the edge entering RESP.
  - If error, rdata=0.
- rdata and err hold their values outside RESP. err is meaningful only while ready=1.
- A store followed by a load to the same address returns the new data; there is no read-during-write hazard because transactions are serialised.
- The address is treated as unsigned. The wait counter width is 4 bits.

Decomposition:
- Shared package dmem_pkg holds:
  - state encoding: IDLE=2'b00, WAIT=2'b01, RESP=2'b10.
  - localparam for the counter width (4).
  - a function for the word-index/range check.
- One sub-module, dmem_array: synchronous-write, synchronous-read single-port word RAM, parameterised by DEPTH_WORDS, with no reset.
- The responder FSM, counter and error logic stay in dmem_responder.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles and release, req=0 for 5 cycles -> ready=0, err=0, rdata=0 throughout.
- Write/read, WAIT_CYCLES=2:
  - Store addr=0x10, wdata=0xDEADBEEF -> ready high exactly 2 cycles after acceptance, err=0.
  - Then load addr=0x10 -> rdata=0xDEADBEEF with ready, err=0.
- Zero wait, WAIT_CYCLES=0: store 0x00000005 at addr=0x0, then load addr=0x0 -> ready in the cycle after each acceptance, rdata=0x00000005.
- Errors:
  - Load addr=0x13 (misaligned) -> ready with err=1, rdata=0.
  - Store to addr=0x400 with DEPTH_WORDS=256 -> err=1, and a subsequent load of word index 0 is unchanged.
- Early req drop: assert req for a store to 0x20 and drop it on the next cycle -> ready still pulses after WAIT_CYCLES, and a later load of 0x20 returns the stored value.
- Reset mid-operation: assert rst_n=0 during WAIT of a store to 0x24 with wdata=0x1234 -> ready never pulses, and after reset a load of 0x24 returns the prior contents, not 0x1234.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types, constants and the access-check helper for the
//                data-memory responder.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  // An access is rejected when the byte address is not word aligned or the
  // word index falls past the end of the array (address treated as unsigned).
  function automatic logic access_err(input logic [31:0] byte_addr,
                                      input int unsigned depth_words);
    logic misaligned;
    logic out_of_range;
    misaligned   = (byte_addr[1:0] != 2'b00);
    out_of_range = ({2'b00, byte_addr[31:2]} >= depth_words);
    return misaligned | out_of_range;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_array
//  Description : Single-port word RAM, synchronous write and synchronous
//                read with read enable. Contents are never reset.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int          AW          = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Write port and registered read port share the single address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      q <= mem[addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Memory end of the CPU load/store port. Accepts one word
//                request over req/ready, inserts WAIT_CYCLES wait states,
//                then completes the access with a one-cycle ready pulse and
//                an err flag for misaligned or out-of-range addresses.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        err,
  output logic [31:0] rdata
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              lat_we;
  logic [31:0]       lat_addr;
  logic [31:0]       lat_wdata;
  logic              rd_valid;

  logic              eff_we;
  logic [31:0]       eff_addr;
  logic [31:0]       eff_wdata;
  logic              eff_err;
  logic              enter_resp;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_q;

  // The access completing on this edge: the live bus when a zero-wait
  // request is accepted straight from IDLE, otherwise the latched request.
  always_comb begin
    eff_we     = lat_we;
    eff_addr   = lat_addr;
    eff_wdata  = lat_wdata;
    enter_resp = 1'b0;
    if (state == IDLE) begin
      eff_we     = we;
      eff_addr   = addr;
      eff_wdata  = wdata;
      enter_resp = req && (WAIT_CYCLES == 0);
    end else if (state == WAIT) begin
      enter_resp = (cnt == CNT_ONE);
    end
  end

  assign eff_err = access_err(eff_addr, DEPTH_WORDS);
  assign ram_we  = enter_resp &  eff_we & ~eff_err;
  assign ram_re  = enter_resp & ~eff_we & ~eff_err;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (eff_addr[AW+1:2]),
    .wdata (eff_wdata),
    .q     (ram_q)
  );

  // RAM read register is not reset, so rdata is gated by a flag that marks
  // whether the last completed load succeeded; a failed load reads as zero.
  assign rdata = ram_q & {DATA_W{rd_valid}};

  // Request FSM, wait counter and registered response flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ready     <= 1'b0;
      err       <= 1'b0;
      rd_valid  <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      ready <= enter_resp;
      if (enter_resp) begin
        err <= eff_err;
        if (!eff_we) begin
          rd_valid <= ~eff_err;
        end
      end
      case (state)
        IDLE: begin
          if (req) begin
            lat_we    <= we;
            lat_addr  <= addr;
            lat_wdata <= wdata;
            cnt       <= WAIT_INIT;
            state     <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder. Two instances
//                (two wait states and zero wait states) are driven with
//                directed and random transactions and compared against a
//                word-array reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int NI    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req   [NI];
  logic        we    [NI];
  logic [31:0] addr  [NI];
  logic [31:0] wdata [NI];
  logic        ready [NI];
  logic        err   [NI];
  logic [31:0] rdata [NI];

  int checks   = 0;
  int failures = 0;

  // Reference model: one word array per instance plus the last load result.
  logic [31:0] mdl_mem   [NI][DEPTH];
  bit          mdl_known [NI][DEPTH];
  logic [31:0] mdl_rdata [NI];
  bit          mdl_rd_known [NI];

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .rst_n(rst_n), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .ready(ready[0]), .err(err[0]), .rdata(rdata[0])
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst_n(rst_n), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .ready(ready[1]), .err(err[1]), .rdata(rdata[1])
  );

  always #5 clk = ~clk;

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic bit exp_err(input logic [31:0] a);
    return ((a % 4) != 0) || ((a / 4) >= DEPTH);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    for (int i = 0; i < NI; i++) begin
      check({tag, " ready"}, {31'd0, ready[i]}, 32'd0);
      check({tag, " err"},   {31'd0, err[i]},   32'd0);
      check({tag, " rdata"}, rdata[i],          32'd0);
    end
  endtask

  // One complete transaction on instance i; hold=1 keeps req asserted and
  // scrambles the buses while the access is in flight.
  task automatic txn(input int i, input bit w, input logic [31:0] a,
                     input logic [31:0] d, input bit hold, input string tag);
    int n;
    bit e;
    int idx;
    @(negedge clk);
    req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
    @(posedge clk); #1;
    e = exp_err(a);
    idx = int'(a / 4);
    if (w) begin
      if (!e) begin
        mdl_mem[i][idx]   = d;
        mdl_known[i][idx] = 1'b1;
      end
    end else if (e) begin
      mdl_rdata[i]    = 32'd0;
      mdl_rd_known[i] = 1'b1;
    end else begin
      mdl_rdata[i]    = mdl_mem[i][idx];
      mdl_rd_known[i] = mdl_known[i][idx];
    end
    if (!hold) req[i] = 1'b0;
    we[i] = ~w; addr[i] = $urandom; wdata[i] = $urandom;
    n = 0;
    while (ready[i] !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    req[i] = 1'b0;
    check({tag, " latency"}, 32'(n), 32'(lat_of(i)));
    check({tag, " err"}, {31'd0, err[i]}, {31'd0, e});
    if (mdl_rd_known[i]) check({tag, " rdata"}, rdata[i], mdl_rdata[i]);
    @(posedge clk); #1;
    check({tag, " pulse_end"}, {31'd0, ready[i]}, 32'd0);
    if (mdl_rd_known[i]) check({tag, " rdata_hold"}, rdata[i], mdl_rdata[i]);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          inst;
    int          sel;
    logic [31:0] a;

    for (int i = 0; i < NI; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
      mdl_rdata[i] = 32'd0; mdl_rd_known[i] = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
        mdl_mem[i][k] = 32'd0; mdl_known[i][k] = 1'b0;
      end
    end

    // Reset then idle.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check_idle_zero("idle");
    end

    // Two wait states: store then load.
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, "w2_st10");
    txn(0, 1'b0, 32'h10, 32'h0,        1'b0, "w2_ld10");
    // Zero wait states.
    txn(1, 1'b1, 32'h0, 32'h00000005, 1'b0, "w0_st0");
    txn(1, 1'b0, 32'h0, 32'h0,        1'b0, "w0_ld0");

    // Fill the words used by the random phase, plus the last word.
    for (int i = 0; i < NI; i++) begin
      for (int k = 1; k < 16; k++) begin
        txn(i, 1'b1, 32'(k * 4), $urandom, 1'($urandom_range(0, 1)), "init");
      end
      txn(i, 1'b1, 32'h3FC, 32'hF00DFACE ^ 32'(i), 1'b0, "bound_st");
      txn(i, 1'b0, 32'h3FC, 32'h0, 1'b0, "bound_ld");
      txn(i, 1'b0, 32'h13,  32'h0, 1'b0, "misalign_ld");
      txn(i, 1'b1, 32'h400, 32'h0BADBAD0, 1'b0, "oor_st");
      txn(i, 1'b0, 32'h0,   32'h0, 1'b0, "ld0_after_oor");
    end

    // Early drop of req during the wait states.
    txn(0, 1'b1, 32'h20, 32'hCAFEF00D, 1'b0, "drop_st20");
    txn(0, 1'b0, 32'h20, 32'h0,        1'b0, "drop_ld20");

    // Reset in the middle of a store.
    txn(0, 1'b1, 32'h24, 32'hA5A50024, 1'b0, "pre_st24");
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h24; wdata[0] = 32'h00001234;
    @(posedge clk); #1;
    req[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid ready_now", {31'd0, ready[0]}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rst_mid ready", {31'd0, ready[0]}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) begin
      mdl_rdata[i] = 32'd0; mdl_rd_known[i] = 1'b1;
    end
    @(posedge clk); #1;
    check_idle_zero("rst_mid after");
    txn(0, 1'b0, 32'h24, 32'h0, 1'b0, "rst_ld24");

    // Random mix on both instances.
    for (int t = 0; t < 120; t++) begin
      inst = $urandom_range(0, 1);
      sel  = $urandom_range(0, 9);
      if (sel < 7) begin
        a = 32'(4 * $urandom_range(0, 15));
      end else if (sel == 7) begin
        a = 32'(4 * $urandom_range(0, 15)) | 32'($urandom_range(1, 3));
      end else if (sel == 8) begin
        a = $urandom | 32'h00000400;
      end else begin
        a = 32'h3FC;
      end
      txn(inst, 1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
